// File: rtl/fifo_wr_pkg.sv
// Shared types and defaults for the FIFO write-side controller.
package fifo_wr_pkg;

    localparam int unsigned DATA_W_DEF       = 8;
    localparam int unsigned DELAY_CYCLES_DEF = 10;
    localparam int unsigned DLY_W            = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        WRITE = 2'd2
    } wr_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level signal.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side FIFO test controller: waits for empty, settles, bursts an incrementing pattern.
// Optional burst-length cap enabled by defining FIFO_WR_BURST_LIMIT_EN.
module fifo_wr_ctrl
    import fifo_wr_pkg::*;
#(
    parameter int unsigned DATA_W       = DATA_W_DEF,
    parameter int unsigned DELAY_CYCLES = DELAY_CYCLES_DEF,
    parameter int unsigned BURST_LEN    = 256
) (
    input  logic              wr_clk,
    input  logic              rst_n,
    input  logic              wr_rst_busy,
    input  logic              empty,
    input  logic              almost_full,
    input  logic              full,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_wr_data,
    output logic              wr_busy
);

    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(DELAY_CYCLES - 1);

    wr_state_e         state_q, state_d;
    logic              wr_en_q, wr_en_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DLY_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              empty_s;

`ifdef FIFO_WR_BURST_LIMIT_EN
    localparam int unsigned BW = $clog2(BURST_LEN + 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(BURST_LEN - 1);

    logic [BW-1:0] burst_q, burst_d;
`else
    logic unused_burst_len;
    assign unused_burst_len = (BURST_LEN != 0);
`endif

    sync_2ff u_empty_sync (
        .clk_i  (wr_clk),
        .rst_ni (rst_n),
        .d_i    (empty),
        .q_o    (empty_s)
    );

    always_ff @(posedge wr_clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wr_en_q <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
`ifdef FIFO_WR_BURST_LIMIT_EN
            burst_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            wr_en_q <= wr_en_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
`ifdef FIFO_WR_BURST_LIMIT_EN
            burst_q <= burst_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        wr_en_d = wr_en_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
`ifdef FIFO_WR_BURST_LIMIT_EN
        burst_d = burst_q;
`endif
        if (wr_rst_busy) begin
            state_d = IDLE;
            wr_en_d = 1'b0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    wr_en_d = 1'b0;
                    if (empty_s) begin
                        state_d = DELAY;
                        cnt_d   = '0;
                        data_d  = '0;
                    end
                end
                DELAY: begin
                    if (cnt_q == DLY_LAST) begin
                        state_d = WRITE;
                        wr_en_d = 1'b1;
`ifdef FIFO_WR_BURST_LIMIT_EN
                        burst_d = '0;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                WRITE: begin
                    // The word on the bus when almost_full is sampled still lands; data then holds.
                    if (almost_full || full) begin
                        state_d = IDLE;
                        wr_en_d = 1'b0;
`ifdef FIFO_WR_BURST_LIMIT_EN
                    end else if (wr_en_q && (burst_q == BURST_LAST)) begin
                        state_d = IDLE;
                        wr_en_d = 1'b0;
`endif
                    end else if (wr_en_q) begin
                        data_d = data_q + 1'b1;
`ifdef FIFO_WR_BURST_LIMIT_EN
                        burst_d = burst_q + 1'b1;
`endif
                    end
                end
                default: begin
                    state_d = IDLE;
                    wr_en_d = 1'b0;
                end
            endcase
        end
        busy_d = (state_d == DELAY) || (state_d == WRITE);
    end

    assign fifo_wr_en   = wr_en_q;
    assign fifo_wr_data = data_q;
    assign wr_busy      = busy_q;

endmodule
